// File: rtl/module_control_unit.sv
// Sequencing front-end for the CPU ALU: accepts one decoded instruction at a time,
// owns an 8 x 16-bit register file, and drives registered ALU operands/opcode.
module module_control_unit #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int INSTR_W    = 3 + 3*REG_ADDR_W + DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [INSTR_W-1:0]    instr,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [2:0]            alu_opcode,
   input  logic [DATA_W-1:0]     alu_result,
   output logic [DATA_W-1:0]     display_value,
   output logic                  display_valid,
   output logic                  done,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   localparam int NUM_REGS = 2**REG_ADDR_W;

   typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
   typedef enum logic [2:0] {
      OP_LOAD    = 3'd0,
      OP_ADD     = 3'd1,
      OP_ADDI    = 3'd2,
      OP_SUB     = 3'd3,
      OP_SUBI    = 3'd4,
      OP_MUL     = 3'd5,
      OP_CLEAR   = 3'd6,
      OP_DISPLAY = 3'd7
   } op_t;

   state_t                state;
   logic [INSTR_W-1:0]    instr_q;
   logic [DATA_W-1:0]     wb_data;
   logic [DATA_W-1:0]     regs [NUM_REGS];

   op_t                   op;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [DATA_W-1:0]     imm;

   assign op  = op_t'(instr_q[INSTR_W-1 -: 3]);
   assign rd  = instr_q[INSTR_W-4 -: REG_ADDR_W];
   assign rs1 = instr_q[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
   assign rs2 = instr_q[INSTR_W-4-2*REG_ADDR_W -: REG_ADDR_W];
   assign imm = instr_q[DATA_W-1:0];

   assign instr_ready = (state == IDLE);
   assign dbg_data    = regs[dbg_addr];

   // done/display_valid are raised on the edge that enters WRITEBACK so the pulse
   // lines up with the WRITEBACK cycle; the register write lands at its end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         instr_q       <= '0;
         wb_data       <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_opcode    <= '0;
         display_value <= '0;
         display_valid <= 1'b0;
         done          <= 1'b0;
         regs          <= '{default: '0};
      end else begin
         done          <= 1'b0;
         display_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               case (op)
                  OP_ADD, OP_SUB, OP_MUL: begin
                     alu_a      <= regs[rs1];
                     alu_b      <= regs[rs2];
                     alu_opcode <= op;
                     state      <= EXECUTE;
                  end
                  OP_ADDI, OP_SUBI: begin
                     alu_a      <= regs[rs1];
                     alu_b      <= imm;
                     alu_opcode <= op;
                     state      <= EXECUTE;
                  end
                  OP_LOAD: begin
                     wb_data <= imm;
                     done    <= 1'b1;
                     state   <= WRITEBACK;
                  end
                  OP_DISPLAY: begin
                     display_value <= regs[rs1];
                     display_valid <= 1'b1;
                     done          <= 1'b1;
                     state         <= WRITEBACK;
                  end
                  default: begin
                     done  <= 1'b1;
                     state <= WRITEBACK;
                  end
               endcase
            end
            EXECUTE: begin
               wb_data <= alu_result;
               done    <= 1'b1;
               state   <= WRITEBACK;
            end
            WRITEBACK: begin
               case (op)
                  OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL: regs[rd] <= wb_data;
                  OP_CLEAR: regs <= '{default: '0};
                  default: ;
               endcase
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_module_control_unit.sv
// Randomized self-checking bench for module_control_unit with a behavioural
// saturating ALU and an instruction-level register-file model.
module tb_module_control_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [27:0] instr = '0;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_opcode;
   logic [15:0] display_value;
   logic        display_valid, done;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] dbg_data;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [15:0] m_regs [8];
   logic [15:0] m_disp;

   always #10 clk = ~clk;

   module_control_unit #(.DATA_W(16), .REG_ADDR_W(3), .INSTR_W(28)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .display_value(display_value),
      .display_valid(display_valid), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [15:0] sat16(input int v);
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return 16'(v);
   endfunction

   // Signed saturating ALU: 1/2 add, 3/4 subtract, 5 multiply.
   function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         3'd1, 3'd2: return sat16(sa + sb);
         3'd3, 3'd4: return sat16(sa - sb);
         3'd5:       return sat16(sa * sb);
         default:    return 16'h0000;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_a, alu_b, alu_opcode);

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [27:0] mk(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
      return {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 16'(imm)};
   endfunction

   task automatic apply_model(input logic [27:0] ins);
      logic [2:0] op, rd, rs1, rs2;
      logic [15:0] imm, b;
      {op, rd, rs1, rs2, imm} = ins;
      b = (op == 3'd2 || op == 3'd4) ? imm : m_regs[rs2];
      case (op)
         3'd0: m_regs[rd] = imm;
         3'd6: for (int i = 0; i < 8; i++) m_regs[i] = '0;
         3'd7: m_disp = m_regs[rs1];
         default: m_regs[rd] = alu_fn(m_regs[rs1], b, op);
      endcase
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check_eq($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, m_regs[i]});
      end
   endtask

   task automatic wait_ready_and_accept(input logic [27:0] ins, output bit ok);
      int c;
      instr = ins;
      instr_valid = 1'b1;
      c = 0;
      @(negedge clk);
      while (!instr_ready && c < 20) begin
         @(negedge clk);
         c++;
      end
      ok = instr_ready;
      if (!ok) begin
         check_eq("accept_timeout", 0, 1);
         instr_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         instr_valid = 1'b0;
         instr = 28'($urandom);
      end
   endtask

   task automatic run_instr(input logic [27:0] ins);
      logic [2:0] op, rd, rs1, rs2;
      logic [15:0] imm, ea, eb;
      bit is_alu, ok;
      int c;
      string tag;
      {op, rd, rs1, rs2, imm} = ins;
      tag = $sformatf("op%0d", op);
      is_alu = (op >= 3'd1 && op <= 3'd5);
      ea = m_regs[rs1];
      eb = (op == 3'd2 || op == 3'd4) ? imm : m_regs[rs2];
      wait_ready_and_accept(ins, ok);
      if (!ok) return;
      c = 1;
      while (!done && c < 10) begin
         @(posedge clk);
         #1;
         c++;
         if (is_alu && c == 2) begin
            check_eq({tag, "_alu_a"}, {16'h0, alu_a}, {16'h0, ea});
            check_eq({tag, "_alu_b"}, {16'h0, alu_b}, {16'h0, eb});
            check_eq({tag, "_alu_op"}, {29'h0, alu_opcode}, {29'h0, op});
         end
      end
      check_eq({tag, "_latency"}, c, is_alu ? 3 : 2);
      check_eq({tag, "_disp_valid"}, {31'h0, display_valid}, {31'h0, op == 3'd7});
      apply_model(ins);
      check_eq({tag, "_disp_value"}, {16'h0, display_value}, {16'h0, m_disp});
      @(posedge clk);
      #1;
      check_eq({tag, "_ready_after"}, {31'h0, instr_ready}, 1);
      check_eq({tag, "_done_single"}, {31'h0, done}, 0);
      check_eq({tag, "_dv_single"}, {31'h0, display_valid}, 0);
      check_regs(tag);
   endtask

   initial begin
      logic [27:0] q[$];
      bit ok, r;
      int base, acc, cyc;

      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_disp = '0;

      // Power-on reset state
      #25;
      check_eq("rst_alu_a", {16'h0, alu_a}, 0);
      check_eq("rst_alu_b", {16'h0, alu_b}, 0);
      check_eq("rst_alu_op", {29'h0, alu_opcode}, 0);
      check_eq("rst_disp", {16'h0, display_value}, 0);
      check_eq("rst_dv", {31'h0, display_valid}, 0);
      check_eq("rst_done", {31'h0, done}, 0);
      check_eq("rst_ready", {31'h0, instr_ready}, 1);
      check_regs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset during EXECUTE discards the ADD
      run_instr(mk(0, 1, 0, 0, 5));
      run_instr(mk(0, 2, 0, 0, 7));
      wait_ready_and_accept(mk(1, 3, 1, 2, 0), ok);
      if (ok) begin
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         for (int i = 0; i < 8; i++) m_regs[i] = '0;
         m_disp = '0;
         check_eq("midrst_done", {31'h0, done}, 0);
         check_eq("midrst_alu_a", {16'h0, alu_a}, 0);
         check_regs("midrst");
         @(negedge clk);
         rst_n = 1'b1;
         repeat (4) begin
            @(posedge clk);
            #1;
            check_eq("midrst_no_done", {31'h0, done}, 0);
            check_eq("midrst_ready", {31'h0, instr_ready}, 1);
         end
         check_regs("midrst_post");
      end

      // Directed sequences with known saturation corners
      run_instr(mk(0, 1, 0, 0, 16'h0005));
      run_instr(mk(0, 2, 0, 0, 16'hFFFD));
      run_instr(mk(1, 3, 1, 2, 0));
      check_eq("add_r3", {16'h0, m_regs[3]}, 32'h0002);
      run_instr(mk(0, 1, 0, 0, 16'h7000));
      run_instr(mk(2, 4, 1, 0, 16'h7000));
      run_instr(mk(4, 5, 4, 0, 16'h0001));
      run_instr(mk(0, 1, 0, 0, 16'h0100));
      run_instr(mk(5, 2, 1, 1, 0));
      run_instr(mk(0, 3, 0, 0, 16'hFFFE));
      run_instr(mk(5, 6, 3, 1, 0));
      run_instr(mk(7, 0, 6, 0, 0));
      check_eq("disp_fe00", {16'h0, display_value}, 32'hFE00);
      run_instr(mk(6, 0, 0, 0, 0));
      check_eq("clear_hold_disp", {16'h0, display_value}, 32'hFE00);
      run_instr(mk(3, 7, 7, 7, 0));

      // Random instruction stream
      repeat (150) run_instr(28'($urandom));

      // Back-to-back offers with instr_valid held high
      q = '{mk(0, 1, 0, 0, 3), mk(1, 1, 1, 1, 0), mk(7, 0, 1, 0, 0)};
      base = done_cnt;
      acc = 0;
      cyc = 0;
      instr_valid = 1'b1;
      while (q.size() > 0 && cyc < 100) begin
         instr = q[0];
         @(negedge clk);
         r = instr_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (r) begin
            apply_model(q[0]);
            void'(q.pop_front());
            acc++;
         end
      end
      instr_valid = 1'b0;
      cyc = 0;
      while (done_cnt - base < 3 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      @(posedge clk);
      #1;
      check_eq("hold_accepts", acc, 3);
      check_eq("hold_dones", done_cnt - base, 3);
      check_eq("hold_r1", {16'h0, m_regs[1]}, 6);
      check_eq("hold_disp", {16'h0, display_value}, {16'h0, m_disp});
      check_regs("hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/module_control_unit.md
Name: module_control_unit

Overview:
Sequencing front-end for the CPU ALU. It accepts one decoded instruction at a time over a valid/ready handshake and holds an 8 x 16-bit register file. It drives the ALU operand and opcode inputs from registered outputs, captures the ALU result, and writes it back. It also executes LOAD, CLEAR and DISPLAY locally, without the ALU.

Parameters:
DATA_W, 16, register, operand and result width (ALU is fixed at 16)
REG_ADDR_W, 3, register index width; NUM_REGS = 2**REG_ADDR_W = 8
INSTR_W, 28, instruction width = 3 + 3*REG_ADDR_W + DATA_W

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  unit can accept an instruction
instr  in  28  [27:25] opcode, [24:22] rd, [21:19] rs1, [18:16] rs2, [15:0] imm
alu_a  out  16  ALU operand A, registered
alu_b  out  16  ALU operand B, registered
alu_opcode  out  3  ALU opcode, registered
alu_result  in  16  combinational ALU result
display_value  out  16  last DISPLAY value, held
display_valid  out  1  1-cycle pulse when display_value updates
done  out  1  1-cycle pulse when an instruction retires
dbg_addr  in  3  register file read address, for the bench
dbg_data  out  16  reg[dbg_addr], combinational

Behaviour:
- Opcodes: LOAD=0, ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5, CLEAR=6, DISPLAY=7.
- Reset (async, rst_n=0):
  - State goes to IDLE; all 8 registers clear to 0.
  - alu_a, alu_b, alu_opcode and display_value go to 0; display_valid and done go to 0.
  - Any in-flight instruction is discarded without writeback.
- States: IDLE, DECODE, EXECUTE, WRITEBACK.
- instr_ready = 1 only in IDLE. instr_valid outside IDLE is ignored and not latched.
- Cycle T, IDLE with instr_valid=1: instr latched; next state DECODE.
- T+1, DECODE:
  - ALU ops (1-5): alu_a <= reg[rs1]; alu_b <= imm for ADDI/SUBI, reg[rs2] for ADD/SUB/MUL; alu_opcode <= opcode; next state EXECUTE.
  - LOAD: wb_data <= imm; next state WRITEBACK.
  - CLEAR, DISPLAY: next state WRITEBACK.
  - ALU outputs change only in DECODE of an ALU op; otherwise they hold.
- T+2, EXECUTE: wb_data <= alu_result, used unmodified (the ALU has already saturated it); next state WRITEBACK.
- WRITEBACK (T+3 for ALU ops, T+2 otherwise):
  - LOAD and ALU ops: reg[rd] <= wb_data.
  - CLEAR: all registers <= 0.
  - DISPLAY: display_value <= reg[rs1]; display_valid pulses 1 cycle; no register write.
  - done pulses 1 cycle; next state IDLE.
- Throughput: next accept at T+4 (ALU op) or T+3 (other ops). A new instruction always sees the previous writeback (no hazard).
- rd == rs1 or rd == rs2: operands are read in DECODE, so the old value is used.
- Register 0 is an ordinary, writable register.
- dbg_data reflects the written value from the cycle after WRITEBACK.
- Unused fields (rs2 and imm where not needed) are don't-care.

Test Plan:
1. Reset mid-operation: issue ADD, assert rst_n=0 during EXECUTE -> no done pulse, all registers 0, instr_ready=1 after release.
2. LOAD r1=0x0005, LOAD r2=0xFFFD, ADD r3=r1+r2 -> ADD done exactly 3 cycles after accept; r3=0x0002; alu_a=0x0005, alu_b=0xFFFD, alu_opcode=1 from T+2.
3. LOAD r1=0x7000, ADDI r4=r1+0x7000 -> r4=0x7FFF (ALU saturation); then SUBI r5=r4-0x0001 -> r5=0x7FFE.
4. LOAD r1=0x0100, MUL r2=r1*r1 -> r2=0x7FFF; LOAD r3=0xFFFE, MUL r6=r3*r1 -> r6=0xFE00.
5. DISPLAY rs1=6 -> display_value=0xFE00 with a single display_valid pulse at T+2; no register changes. CLEAR -> all dbg_data reads 0; display_value still holds 0xFE00.
6. Hold instr_valid=1 continuously with 3 queued instructions, including ADD r1=r1+r1 with r1=3 -> each accepted only while instr_ready=1, none dropped or duplicated; r1=6.
